slow_clock_decimator: RTL and testbench
=======================================

// Module: slow_clock_decimator
// PURPOSE
// Boxcar decimator clocked by the toggle output of the derived clock divider. Runs on the
// fast clk; treats the divider's square wave as a plain register-driven signal in the clk domain
// (no synchroniser). Accumulates every data_i sample between consecutive rising edges of slow_clk_i.
// On each rising edge, presents the window's sum, sample count and shifted mean with a one-cycle valid strobe.
// PARAMETERS
// DW    14  width of signed input sample data_i
// CNTW  16  width of window sample counter; max window = 2**CNTW-1 samples
// SHIFT 4   right-shift applied to the sum to form mean_o; 0..CNTW
// ACCW  = DW+CNTW (localparam)  accumulator width; cannot overflow for count <= 2**CNTW-1
// PORTS
// clk         in   1     system clock
// rst_n       in   1     asynchronous active-low reset
// enable_i    in   1     1 = run; 0 = return to IDLE, clear accumulator
// slow_clk_i  in   1     divided square wave from the derived clock divider, clk-domain
// data_i      in   DW    signed sample, valid every clk cycle
// sum_o       out  ACCW  signed sum of last completed window
// count_o     out  CNTW  number of samples in last completed window
// mean_o      out  DW    signed (sum >>> SHIFT), saturated to DW
// valid_o     out  1     one-cycle strobe: sum_o/count_o/mean_o/ovf_o updated
// ovf_o       out  1     last completed window hit the count limit (truncated)
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, prev=0, acc=0, cnt=0.
//   All outputs reset: sum_o=0, count_o=0, mean_o=0, valid_o=0, ovf_o=0.
// - Edge: rise = slow_clk_i & ~prev; prev <= slow_clk_i every cycle, in all states.
// - States:
//   IDLE:  enable_i=1 -> WAIT.
//   WAIT:  discard the partial window. rise -> ACCUM with acc<=data_i, cnt<=1. enable_i=0 -> IDLE.
//   ACCUM: no rise -> acc+=data_i, cnt+=1.
//          rise -> outputs <= {acc, cnt, sat(acc>>>SHIFT), sat_flag}, valid_o<=1 next cycle;
//          then acc<=data_i, cnt<=1. The edge-cycle sample belongs to the NEW window.
//          enable_i=0 -> IDLE.
// - Window = samples at cycles t_k .. t_(k+1)-1. valid_o is high at cycle t_(k+1)+1 (latency 1),
//   exactly one cycle wide.
// - Count limit: when cnt == 2**CNTW-1, stop accumulating, hold acc/cnt, set sat_flag.
//   Next rise reports ovf_o=1 and clears sat_flag.
// - Mean saturation: if (acc>>>SHIFT) is outside [-2**(DW-1), 2**(DW-1)-1], clamp to that bound.
// - rise and enable_i=0 in the same cycle: enable wins. Go to IDLE, no valid_o, outputs hold.
// - enable_i deasserted mid-window: partial window discarded; outputs keep their last values.
// - First rise after enable: only opens a window; the first valid_o comes on the second rise.
// - slow_clk_i stuck (N huge): window runs to the count limit, then waits; no spurious valid_o.
// - Async reset mid-window: everything cleared immediately; valid_o never glitches high.
// STRUCTURE
// - Shared package/header: state encoding (IDLE=2'd0, WAIT=2'd1, ACCUM=2'd2) and a saturating
//   signed-resize function, shared with the other decimation stages.
// - One sub-module: rise_edge_detect (clk, rst_n, d -> rise). Everything else is flat.
// TESTING
// 1. Divider N=3, DIVIDE=1 (rise every 16 clk), data_i=100, SHIFT=4
//    -> from the 2nd rise: sum_o=1600, count_o=16, mean_o=100, ovf_o=0, valid_o every 16 cycles.
// 2. data_i ramp 0,1,2,... with 16-sample windows
//    -> consecutive sums differ by 256; confirms the edge-cycle sample starts the new window.
// 3. data_i=-8192, CNTW=4, rise every 40 cycles
//    -> count_o=15, ovf_o=1, sum_o=-122880, mean_o=-7680.
// 4. data_i=8191, SHIFT=0, 16-sample window -> mean_o saturates to 8191; sum_o=131056.
// 5. enable_i dropped on the same cycle as a rise -> no valid_o; after re-enable, the first valid_o
//    is at the 2nd subsequent rise.
// 6. rst_n pulsed low mid-window -> all outputs 0 within the same cycle; normal operation resumes
//    after two rises.

Source files
------------

// File: rtl/slow_clock_decimator_pkg.sv
// Shared decimation-stage definitions: FSM state encoding and a saturating signed resize.
package slow_clock_decimator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACCUM = 2'd2
  } dec_state_e;

  // Clamp a wide signed value into the range of a w-bit signed number; caller narrows the result.
  function automatic logic signed [63:0] sat_resize(input logic signed [63:0] v,
                                                   input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/slow_clock_decimator_edge.sv
// Rising-edge detector for a clk-domain register-driven signal (no synchroniser).
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= d;
    end
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/slow_clock_decimator.sv
// Boxcar decimator: sums data_i between rising edges of slow_clk_i, reports sum/count/mean.
// state    | meaning
// ST_IDLE  | disabled, accumulator cleared
// ST_WAIT  | enabled, waiting for the first rise to open a window
// ST_ACCUM | window open, accumulating; each rise closes it and opens the next
module slow_clock_decimator #(
  parameter  int DW    = 14,
  parameter  int CNTW  = 16,
  parameter  int SHIFT = 4,
  localparam int ACCW  = DW + CNTW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  input  logic                   slow_clk_i,
  input  logic signed [DW-1:0]   data_i,
  output logic signed [ACCW-1:0] sum_o,
  output logic [CNTW-1:0]        count_o,
  output logic signed [DW-1:0]   mean_o,
  output logic                   valid_o,
  output logic                   ovf_o
);
  import slow_clock_decimator_pkg::*;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  dec_state_e             state;
  logic signed [ACCW-1:0] acc;
  logic [CNTW-1:0]        cnt;
  logic                   sat_flag;
  logic                   rise;
  logic signed [DW-1:0]   mean_next;

  rise_edge_detect u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (slow_clk_i),
    .rise (rise)
  );

  assign mean_next = DW'(sat_resize(64'(acc >>> SHIFT), DW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      acc      <= '0;
      cnt      <= '0;
      sat_flag <= 1'b0;
      sum_o    <= '0;
      count_o  <= '0;
      mean_o   <= '0;
      valid_o  <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      // Disable overrides a coincident rise: the open window is dropped, outputs hold.
      if (!enable_i) begin
        state    <= ST_IDLE;
        acc      <= '0;
        cnt      <= '0;
        sat_flag <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (rise) begin
              state    <= ST_ACCUM;
              acc      <= ACCW'(data_i);
              cnt      <= CNTW'(1);
              sat_flag <= 1'b0;
            end
          end
          ST_ACCUM: begin
            if (rise) begin
              sum_o    <= acc;
              count_o  <= cnt;
              mean_o   <= mean_next;
              ovf_o    <= sat_flag;
              valid_o  <= 1'b1;
              acc      <= ACCW'(data_i);
              cnt      <= CNTW'(1);
              sat_flag <= 1'b0;
            end else if (cnt == CNT_MAX) begin
              sat_flag <= 1'b1;
            end else begin
              acc <= acc + ACCW'(data_i);
              cnt <= cnt + CNTW'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slow_clock_decimator.sv
// Directed bench for slow_clock_decimator: three parameterisations share one stimulus stream.
module tb_slow_clock_decimator;

  logic clk;
  logic rst_n;
  logic enable;
  logic slow_clk;
  logic signed [13:0] data;

  logic signed [29:0] sum0;
  logic [15:0]        cnt0;
  logic signed [13:0] mean0;
  logic               v0, ovf0;
  logic signed [17:0] sum1;
  logic [3:0]         cnt1;
  logic signed [13:0] mean1;
  logic               v1, ovf1;
  logic signed [29:0] sum2;
  logic [15:0]        cnt2;
  logic signed [13:0] mean2;
  logic               v2, ovf2;

  int n_checks = 0;
  int n_fail   = 0;

  int period    = 16;
  int ph        = 8;
  int data_val  = 0;
  int ramp_v    = 0;
  bit ramp_mode = 0;
  bit ramp_arm  = 0;
  bit drop_arm  = 0;

  slow_clock_decimator #(.DW(14), .CNTW(16), .SHIFT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .slow_clk_i(slow_clk), .data_i(data),
    .sum_o(sum0), .count_o(cnt0), .mean_o(mean0), .valid_o(v0), .ovf_o(ovf0)
  );

  slow_clock_decimator #(.DW(14), .CNTW(4), .SHIFT(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .slow_clk_i(slow_clk), .data_i(data),
    .sum_o(sum1), .count_o(cnt1), .mean_o(mean1), .valid_o(v1), .ovf_o(ovf1)
  );

  slow_clock_decimator #(.DW(14), .CNTW(16), .SHIFT(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .slow_clk_i(slow_clk), .data_i(data),
    .sum_o(sum2), .count_o(cnt2), .mean_o(mean2), .valid_o(v2), .ovf_o(ovf2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic vld(input int sel);
    case (sel)
      0:       return v0;
      1:       return v1;
      default: return v2;
    endcase
  endfunction

  // One clk cycle: outputs are stable at the falling edge, then the next inputs are driven.
  task automatic step();
    @(negedge clk);
    ph = (ph + 1) % period;
    slow_clk = (ph < period / 2);
    if (ph == 0 && ramp_arm) begin
      ramp_arm  = 0;
      ramp_mode = 1;
      ramp_v    = 0;
    end
    if (ph == 0 && drop_arm) begin
      drop_arm = 0;
      enable   = 1'b0;
    end
    if (ramp_mode) begin
      data = 14'(ramp_v);
      ramp_v++;
    end else begin
      data = 14'(data_val);
    end
  endtask

  task automatic wait_win(input string tag, input int sel, input int gap);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!vld(sel) && n < gap + 8);
    check({tag, " gap"}, n, gap);
  endtask

  task automatic end_pulse(input string tag, input int sel);
    step();
    check({tag, " width"}, vld(sel), 0);
  endtask

  task automatic chk_dut(input string tag, input int s, input int c, input int m, input int o);
    check({tag, " sum"},   sum0, s);
    check({tag, " count"}, cnt0, c);
    check({tag, " mean"},  mean0, m);
    check({tag, " ovf"},   ovf0, o);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    enable   = 1'b0;
    slow_clk = 1'b0;
    data     = '0;

    @(negedge clk);
    chk_dut("reset", 0, 0, 0, 0);
    check("reset valid", v0, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    data_val = 100;

    // Constant 100, 16-sample windows; first valid only after the second rise.
    wait_win("t1 first", 0, 25);
    chk_dut("t1 w1", 1600, 16, 100, 0);
    end_pulse("t1 w1", 0);
    wait_win("t1 second", 0, 15);
    chk_dut("t1 w2", 1600, 16, 100, 0);
    end_pulse("t1 w2", 0);

    // Ramp starting on a rise cycle: windows 0..15, 16..31, 32..47.
    ramp_arm = 1;
    wait_win("t2 pre", 0, 15);
    chk_dut("t2 pre", 1600, 16, 100, 0);
    end_pulse("t2 pre", 0);
    wait_win("t2 r1", 0, 15);
    chk_dut("t2 r1", 120, 16, 7, 0);
    end_pulse("t2 r1", 0);
    wait_win("t2 r2", 0, 15);
    chk_dut("t2 r2", 376, 16, 23, 0);
    end_pulse("t2 r2", 0);
    wait_win("t2 r3", 0, 15);
    chk_dut("t2 r3", 632, 16, 39, 0);
    end_pulse("t2 r3", 0);

    // Full-scale positive input; SHIFT=0 instance must clamp the mean.
    ramp_mode = 0;
    data_val  = 8191;
    wait_win("t4 mixed", 0, 15);
    end_pulse("t4 mixed", 0);
    wait_win("t4 full", 0, 15);
    chk_dut("t4 dut", 131056, 16, 8191, 0);
    check("t4 s0 valid", v2, 1);
    check("t4 s0 sum",   sum2, 131056);
    check("t4 s0 mean",  mean2, 8191);
    end_pulse("t4 full", 0);

    // 40-cycle windows of -8192: CNTW=4 instance hits the count limit.
    period   = 40;
    data_val = -8192;
    wait_win("t3 mixed", 1, 39);
    end_pulse("t3 mixed", 1);
    wait_win("t3 full", 1, 39);
    check("t3 c4 count", cnt1, 15);
    check("t3 c4 ovf",   ovf1, 1);
    check("t3 c4 sum",   sum1, -122880);
    check("t3 c4 mean",  mean1, -7680);
    chk_dut("t3 dut", -327680, 40, -8192, 0);
    end_pulse("t3 full", 1);

    // Enable dropped on the rise cycle: no valid, outputs hold, restart takes two rises.
    period   = 16;
    drop_arm = 1;
    n = 0;
    while (drop_arm && n < 40) begin
      step();
      n++;
    end
    check("t5 drop reached", n, 14);
    step();
    check("t5 drop valid", v0, 0);
    check("t5 hold sum",   sum0, -327680);
    check("t5 hold count", cnt0, 40);
    enable = 1'b1;
    wait_win("t5 restart", 0, 32);
    chk_dut("t5 restart", -131072, 16, -8192, 0);
    end_pulse("t5 restart", 0);

    // Async reset in mid-window clears outputs without waiting for a clock edge.
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk_dut("t6 async", 0, 0, 0, 0);
    check("t6 async valid", v0, 0);
    check("t6 async c4 sum", sum1, 0);
    step();
    step();
    rst_n = 1'b1;
    wait_win("t6 resume", 0, 24);
    chk_dut("t6 resume", -131072, 16, -8192, 0);
    end_pulse("t6 resume", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
